// File: rtl/seizure_alarm_filter_if.sv
// Host-side bundle for the seizure alarm filter: control/decision inputs and alarm outputs.
interface seizure_alarm_filter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic             seizure;
    logic             sample_valid;
    logic             alarm;
    logic             onset_pulse;
    logic [CNT_W-1:0] event_count;
    logic [1:0]       state_dbg;

    modport master (
        output en, seizure, sample_valid,
        input  alarm, onset_pulse, event_count, state_dbg
    );

    modport slave (
        input  en, seizure, sample_valid,
        output alarm, onset_pulse, event_count, state_dbg
    );
endinterface

// File: rtl/seizure_alarm_filter.sv
// Debounces raw per-window seizure decisions into a latched alarm:
// M-of-N onset, fixed hold time, then K consecutive negatives to release.
module seizure_alarm_filter #(
    parameter int unsigned WIN_LEN    = 8,
    parameter int unsigned ONSET_CNT  = 6,
    parameter int unsigned HOLD_MIN   = 16,
    parameter int unsigned OFFSET_CNT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    seizure_alarm_filter_if.slave  bus
);
    localparam int unsigned POP_W  = $clog2(WIN_LEN + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_MIN + 1);
    localparam int unsigned NEG_W  = $clog2(OFFSET_CNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIN_LEN-1:0] hist_q, hist_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [NEG_W-1:0]   neg_cnt_q, neg_cnt_d;
    logic [CNT_W-1:0]   event_count_q, event_count_d;
    logic               alarm_q, alarm_d;
    logic               onset_pulse_q, onset_pulse_d;

    logic               accept;
    logic [WIN_LEN-1:0] hist_shift;
    logic [POP_W-1:0]   pop_next;

    assign accept     = bus.sample_valid & ~bus.en;
    assign hist_shift = (hist_q << 1) | WIN_LEN'(bus.seizure);

    // Popcount of the history including the current decision.
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < int'(WIN_LEN); i++) begin
            pop_next = pop_next + POP_W'(hist_shift[i]);
        end
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d       = state_q;
        hist_d        = hist_q;
        hold_cnt_d    = hold_cnt_q;
        neg_cnt_d     = neg_cnt_q;
        event_count_d = event_count_q;
        onset_pulse_d = 1'b0;

        if (accept) begin
            hist_d = hist_shift;
            case (state_q)
                IDLE: begin
                    if (pop_next >= POP_W'(ONSET_CNT)) begin
                        state_d       = HOLD;
                        hold_cnt_d    = HOLD_W'(HOLD_MIN - 1);
                        onset_pulse_d = 1'b1;
                        if (event_count_q != {CNT_W{1'b1}}) begin
                            event_count_d = event_count_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_d   = RELEASE;
                        neg_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end
                end
                RELEASE: begin
                    if (bus.seizure) begin
                        neg_cnt_d = '0;
                    end else if (neg_cnt_q == NEG_W'(OFFSET_CNT - 1)) begin
                        state_d   = IDLE;
                        hist_d    = '0;
                        neg_cnt_d = '0;
                    end else begin
                        neg_cnt_d = neg_cnt_q + NEG_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        alarm_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            hist_q        <= '0;
            hold_cnt_q    <= '0;
            neg_cnt_q     <= '0;
            event_count_q <= '0;
            alarm_q       <= 1'b0;
            onset_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hist_q        <= hist_d;
            hold_cnt_q    <= hold_cnt_d;
            neg_cnt_q     <= neg_cnt_d;
            event_count_q <= event_count_d;
            alarm_q       <= alarm_d;
            onset_pulse_q <= onset_pulse_d;
        end
    end

    assign bus.alarm       = alarm_q;
    assign bus.onset_pulse = onset_pulse_q;
    assign bus.event_count = event_count_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_seizure_alarm_filter.sv
// Directed bench for seizure_alarm_filter; a second instance with CNT_W=2 checks saturation.
module tb_seizure_alarm_filter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seizure_alarm_filter_if #(.CNT_W(16)) bus_a ();
    seizure_alarm_filter_if #(.CNT_W(2))  bus_b ();

    seizure_alarm_filter #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    seizure_alarm_filter #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge with the given inputs on both instances; returns 1 time unit after the edge.
    task automatic tick(input logic v, input logic s, input logic e);
        bus_a.sample_valid = v; bus_a.seizure = s; bus_a.en = e;
        bus_b.sample_valid = v; bus_b.seizure = s; bus_b.en = e;
        @(posedge clk);
        #1;
        bus_a.sample_valid = 1'b0; bus_a.en = 1'b0;
        bus_b.sample_valid = 1'b0; bus_b.en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    logic [7:0] pat;
    logic [7:0] rel;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus_a.sample_valid = 1'b0; bus_a.seizure = 1'b0; bus_a.en = 1'b0;
        bus_b.sample_valid = 1'b0; bus_b.seizure = 1'b0; bus_b.en = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_alarm", 32'(bus_a.alarm), 0);
        check("rst_pulse", 32'(bus_a.onset_pulse), 0);
        check("rst_count", 32'(bus_a.event_count), 0);
        check("rst_state", 32'(bus_a.state_dbg), 0);

        // 5 positives in 8 samples: below threshold
        pat = 8'b1101_1010;
        for (int i = 7; i >= 0; i--) begin
            tick(1'b1, pat[i], 1'b0);
            check("m5_alarm", 32'(bus_a.alarm), 0);
            check("m5_pulse", 32'(bus_a.onset_pulse), 0);
        end
        check("m5_count", 32'(bus_a.event_count), 0);

        // 6 consecutive positives trigger on the 6th
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            check("pre_onset_alarm", 32'(bus_a.alarm), 0);
        end
        tick(1'b1, 1'b1, 1'b0);
        check("onset_alarm", 32'(bus_a.alarm), 1);
        check("onset_pulse", 32'(bus_a.onset_pulse), 1);
        check("onset_count", 32'(bus_a.event_count), 1);
        check("onset_state", 32'(bus_a.state_dbg), 1);
        tick(1'b1, 1'b0, 1'b1);
        check("pulse_drop_en1", 32'(bus_a.onset_pulse), 0);
        check("frozen_state", 32'(bus_a.state_dbg), 1);

        // Hold spans 16 samples, then 4 negatives release
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (i <= 15) begin
                check("hold_state", 32'(bus_a.state_dbg), 1);
                check("hold_alarm", 32'(bus_a.alarm), 1);
            end else if (i <= 19) begin
                check("release_state", 32'(bus_a.state_dbg), 2);
                check("release_alarm", 32'(bus_a.alarm), 1);
            end else begin
                check("idle_state", 32'(bus_a.state_dbg), 0);
                check("idle_alarm", 32'(bus_a.alarm), 0);
                check("hist_clear", 32'(dut_a.hist_q), 0);
            end
        end
        check("pulse_once", 32'(bus_a.onset_pulse), 0);

        // Second onset, then a release stream with a positive in it
        for (int i = 1; i <= 6; i++) tick(1'b1, 1'b1, 1'b0);
        check("onset2_count", 32'(bus_a.event_count), 2);
        for (int i = 1; i <= 16; i++) tick(1'b1, 1'b0, 1'b0);
        check("enter_release", 32'(bus_a.state_dbg), 2);
        rel = 8'b0001_0000;
        for (int i = 7; i >= 0; i--) begin
            tick(1'b1, 1'b1, 1'b1);
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b1, rel[i], 1'b0);
            check("rel_alarm", 32'(bus_a.alarm), (i == 0) ? 32'd0 : 32'd1);
        end
        check("rel_count", 32'(bus_a.event_count), 2);

        // History cleared on release: 5 positives not enough, 6th triggers
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            check("post_rel_alarm", 32'(bus_a.alarm), 0);
        end
        tick(1'b1, 1'b1, 1'b0);
        check("post_rel_onset", 32'(bus_a.alarm), 1);
        check("post_rel_count", 32'(bus_a.event_count), 3);

        // Reset during HOLD
        tick(1'b1, 1'b1, 1'b0);
        do_reset();
        check("midrst_alarm", 32'(bus_a.alarm), 0);
        check("midrst_count", 32'(bus_a.event_count), 0);
        check("midrst_state", 32'(bus_a.state_dbg), 0);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            check("midrst_no_trig", 32'(bus_a.alarm), 0);
        end
        tick(1'b1, 1'b1, 1'b0);
        check("midrst_retrig", 32'(bus_a.alarm), 1);
        check("midrst_pulse", 32'(bus_a.onset_pulse), 1);

        // Saturating 2-bit event counter over 5 alarm cycles
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int i = 1; i <= 6; i++) tick(1'b1, 1'b1, 1'b0);
            check("sat_pulse", 32'(bus_b.onset_pulse), 1);
            check("sat_count", 32'(bus_b.event_count), (c >= 2) ? 32'd3 : 32'(c + 1));
            for (int i = 1; i <= 20; i++) tick(1'b1, 1'b0, 1'b0);
            check("sat_released", 32'(bus_b.alarm), 0);
        end
        check("wide_count", 32'(bus_a.event_count), 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
